// File: rtl/sata_regs_slave.sv
// sata_regs_slave: register-domain endpoint executing one FIFO request at a time
// against a small register bank, returning a spaced one-cycle ack with read data.
module sata_regs_slave #(
  parameter int          ADDR_BITS  = 4,
  parameter int          CTRL_COUNT = 8,
  parameter int          ACK_GAP    = 3,
  parameter logic [31:0] ID_VALUE   = 32'h5A7A0001
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic                    req_val,
  input  logic                    req_rd,
  input  logic [ADDR_BITS-1:0]    req_addr,
  input  logic [31:0]             req_wdata,
  output logic                    req_pop,
  output logic [31:0]             rsp_rdata,
  output logic                    rsp_ack,
  input  logic [31:0]             irq_set,
  input  logic [31:0]             status_in,
  output logic [32*CTRL_COUNT-1:0] ctrl_flat,
  output logic                    irq
);
  localparam int CW = $clog2(ACK_GAP + 1);
  typedef enum logic [1:0] {IDLE, EXEC, ACK, HOLD} state_t;
  state_t                        state_q, state_d;
  logic                          rd_q, rd_d, pop_q, pop_d, ack_q, ack_d, irq_q, irq_d, wr;
  logic [ADDR_BITS-1:0]          addr_q, addr_d;
  logic [31:0]                   wdata_q, wdata_d, rdata_q, rdata_d, is_q, is_d, ie_q, ie_d;
  logic [31:0]                   rval, clr;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [CTRL_COUNT-1:0][31:0]   ctrl_q, ctrl_d;
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pop_d   = 1'b0;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    wr      = state_q == EXEC && !rd_q;
    rval    = addr_q == ADDR_BITS'(0) ? is_q :
              addr_q == ADDR_BITS'(1) ? ie_q :
              addr_q == ADDR_BITS'(2) ? status_in :
              addr_q == ADDR_BITS'(3) ? ID_VALUE : 32'h0;
    for (int k = 0; k < CTRL_COUNT; k++) begin
      if (addr_q == ADDR_BITS'(4 + k)) rval = ctrl_q[k];
      if (wr && addr_q == ADDR_BITS'(4 + k)) ctrl_d[k] = wdata_q;
    end
    ie_d  = wr && addr_q == ADDR_BITS'(1) ? wdata_q : ie_q;
    clr   = wr && addr_q == ADDR_BITS'(0) ? wdata_q : 32'h0;
    // set wins over a simultaneous write-1-to-clear of the same bit
    is_d  = (is_q & ~clr) | irq_set;
    irq_d = |(is_d & ie_d);
    case (state_q)
      IDLE: if (req_val) begin
        state_d = EXEC;
        pop_d   = 1'b1;
        rd_d    = req_rd;
        addr_d  = req_addr;
        wdata_d = req_wdata;
      end
      EXEC: begin
        state_d = ACK;
        ack_d   = 1'b1;
        rdata_d = rd_q ? rval : rdata_q;
      end
      ACK: begin
        state_d = HOLD;
        cnt_d   = CW'(ACK_GAP - 1);
      end
      HOLD: begin
        state_d = cnt_q == '0 ? IDLE : HOLD;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pop_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      is_q    <= '0;
      ie_q    <= '0;
      irq_q   <= 1'b0;
      cnt_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pop_q   <= pop_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      is_q    <= is_d;
      ie_q    <= ie_d;
      irq_q   <= irq_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end
  assign req_pop   = pop_q;
  assign rsp_ack   = ack_q;
  assign rsp_rdata = rdata_q;
  assign irq       = irq_q;
  assign ctrl_flat = ctrl_q;
endmodule

// File: tb/tb_sata_regs_slave.sv
// tb_sata_regs_slave: directed checks of access timing, register map, IS/irq
// behaviour, back-to-back spacing and mid-transaction reset.
module tb_sata_regs_slave;
  logic         ACLK = 1'b0;
  logic         ARESETN;
  logic         req_val, req_rd, req_pop, rsp_ack, irq;
  logic [3:0]   req_addr;
  logic [31:0]  req_wdata, rsp_rdata, irq_set, status_in;
  logic [255:0] ctrl_flat;
  logic [255:0] exp_ctrl;
  logic [31:0]  last_rd;
  int           total = 0, passed = 0, failed = 0;

  sata_regs_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .req_val(req_val), .req_rd(req_rd),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_pop(req_pop),
    .rsp_rdata(rsp_rdata), .rsp_ack(rsp_ack), .irq_set(irq_set),
    .status_in(status_in), .ctrl_flat(ctrl_flat), .irq(irq)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while the DUT is IDLE; returns at the negedge of the
  // first cycle in which a new request can be captured again.
  task automatic do_req(input string tag, input logic rd, input logic [3:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic [31:0] set_exec, input logic [31:0] st_after);
    req_val = 1'b1; req_rd = rd; req_addr = addr; req_wdata = wd;
    @(negedge ACLK);
    check({tag, " pop c1"}, 256'(req_pop), 256'(1));
    check({tag, " ack c1"}, 256'(rsp_ack), 256'(0));
    req_val = 1'b0; req_addr = ~addr; req_wdata = ~wd;
    irq_set = set_exec;
    @(negedge ACLK);
    irq_set = '0;
    status_in = st_after;
    check({tag, " ack c2"}, 256'(rsp_ack), 256'(1));
    check({tag, " pop c2"}, 256'(req_pop), 256'(0));
    if (rd) last_rd = exp_rd;
    else if (addr >= 4 && addr <= 11) exp_ctrl[32*(int'(addr)-4) +: 32] = wd;
    check({tag, " rdata"}, 256'(rsp_rdata), 256'(last_rd));
    @(negedge ACLK);
    check({tag, " ctrl"}, ctrl_flat, exp_ctrl);
    check({tag, " ack hold"}, 256'(rsp_ack), 256'(0));
    repeat (3) @(negedge ACLK);
  endtask

  initial begin
    logic [3:0]  b_addr [3];
    logic        b_rd   [3];
    logic [31:0] b_wd   [3];
    int          ack_t  [3];
    int          n, na;
    ARESETN = 1'b0; req_val = 1'b0; req_rd = 1'b0; req_addr = '0; req_wdata = '0;
    irq_set = '0; status_in = '0; exp_ctrl = '0; last_rd = '0;
    repeat (2) @(negedge ACLK);
    check("rst pop", 256'(req_pop), 256'(0));
    check("rst ack", 256'(rsp_ack), 256'(0));
    check("rst rdata", 256'(rsp_rdata), 256'(0));
    check("rst irq", 256'(irq), 256'(0));
    check("rst ctrl", ctrl_flat, 256'(0));
    ARESETN = 1'b1;
    @(negedge ACLK);

    do_req("wr4", 1'b0, 4'd4, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    do_req("rd4", 1'b1, 4'd4, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0);
    check("ctrl0", 256'(ctrl_flat[31:0]), 256'(32'hDEADBEEF));
    do_req("rd_id", 1'b1, 4'd3, 32'h0, 32'h5A7A0001, 32'h0, 32'h0);
    do_req("rd15", 1'b1, 4'd15, 32'h0, 32'h0, 32'h0, 32'h0);
    do_req("wr15", 1'b0, 4'd15, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);
    do_req("rd_ie0", 1'b1, 4'd1, 32'h0, 32'h0, 32'h0, 32'h0);

    // three queued requests with req_val held high; next entry shown on each pop
    b_addr = '{4'd6, 4'd7, 4'd6};
    b_rd   = '{1'b0, 1'b0, 1'b1};
    b_wd   = '{32'h11111111, 32'h22222222, 32'h0};
    n = 0; na = 0;
    req_val = 1'b1; req_rd = b_rd[0]; req_addr = b_addr[0]; req_wdata = b_wd[0];
    for (int c = 0; c < 60 && na < 3; c++) begin
      @(negedge ACLK);
      if (req_pop) begin
        n++;
        if (n < 3) begin
          req_rd = b_rd[n]; req_addr = b_addr[n]; req_wdata = b_wd[n];
        end else req_val = 1'b0;
      end
      if (rsp_ack) begin
        if (na < 3) ack_t[na] = c;
        na++;
      end
    end
    req_val = 1'b0;
    check("b2b pops", 256'(n), 256'(3));
    check("b2b acks", 256'(na), 256'(3));
    check("b2b gap1", 256'(ack_t[1] - ack_t[0]), 256'(6));
    check("b2b gap2", 256'(ack_t[2] - ack_t[1]), 256'(6));
    check("b2b rdata", 256'(rsp_rdata), 256'(32'h11111111));
    exp_ctrl[32*2 +: 32] = 32'h11111111;
    exp_ctrl[32*3 +: 32] = 32'h22222222;
    last_rd = 32'h11111111;
    repeat (4) @(negedge ACLK);
    check("b2b ctrl", ctrl_flat, exp_ctrl);

    do_req("wr_ie", 1'b0, 4'd1, 32'h20, 32'h0, 32'h0, 32'h0);
    check("irq idle", 256'(irq), 256'(0));
    irq_set = 32'h20;
    @(negedge ACLK);
    irq_set = '0;
    check("irq set", 256'(irq), 256'(1));
    do_req("rd_is", 1'b1, 4'd0, 32'h0, 32'h20, 32'h0, 32'h0);
    do_req("clr_is", 1'b0, 4'd0, 32'h20, 32'h0, 32'h0, 32'h0);
    check("irq clr", 256'(irq), 256'(0));
    do_req("rd_is0", 1'b1, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0);
    do_req("clr_set", 1'b0, 4'd0, 32'h20, 32'h0, 32'h20, 32'h0);
    check("irq set wins", 256'(irq), 256'(1));
    do_req("rd_is_set", 1'b1, 4'd0, 32'h0, 32'h20, 32'h0, 32'h0);

    status_in = 32'h12345678;
    do_req("rd_stat", 1'b1, 4'd2, 32'h0, 32'h12345678, 32'h0, 32'h0);

    // reset during EXEC of a write to addr 5
    req_val = 1'b1; req_rd = 1'b0; req_addr = 4'd5; req_wdata = 32'hCAFEF00D;
    @(negedge ACLK);
    check("mid pop", 256'(req_pop), 256'(1));
    ARESETN = 1'b0;
    #1;
    check("mid rst pop", 256'(req_pop), 256'(0));
    check("mid rst rdata", 256'(rsp_rdata), 256'(0));
    check("mid rst irq", 256'(irq), 256'(0));
    check("mid rst ctrl", ctrl_flat, 256'(0));
    exp_ctrl = '0; last_rd = '0;
    repeat (2) @(negedge ACLK);
    check("mid rst ack", 256'(rsp_ack), 256'(0));
    check("mid rst ctrl1", 256'(ctrl_flat[63:32]), 256'(0));
    ARESETN = 1'b1;
    do_req("retry", 1'b0, 4'd5, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0);
    check("retry ctrl1", 256'(ctrl_flat[63:32]), 256'(32'hCAFEF00D));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
